// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_sequencer
// Brief    : Generates the memory-game box sequence and plays it back through
//            the draw datapath with a draw/hold/erase/gap cycle per step.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 50_000_000,
    parameter int          OFF_CYCLES = 25_000_000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iNewPattern,
    input  logic [3:0] iLevel,
    input  logic       iDrawDone,
    output logic       oDrawReq,
    output logic [1:0] oBoxIdx,
    output logic       oClear,
    output logic [3:0] oStep,
    output logic       oBusy,
    output logic       oDone,
    input  logic [3:0] iRdAddr,
    output logic [1:0] oRdData
);

    localparam int              c_AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              c_DEPTH    = 1 << c_AW;
    localparam logic [c_AW-1:0] c_GEN_LAST = c_AW'(MAX_LEN - 1);
    localparam logic [4:0]      c_MAX_LEN  = 5'(MAX_LEN);
    localparam logic [31:0]     c_ON_LOAD  = 32'(ON_CYCLES - 1);
    localparam logic [31:0]     c_OFF_LOAD = 32'(OFF_CYCLES - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_GEN   = 3'd1;
    localparam logic [2:0] c_PRE   = 3'd2;
    localparam logic [2:0] c_DRAW  = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;
    localparam logic [2:0] c_ERASE = 3'd5;
    localparam logic [2:0] c_GAP   = 3'd6;
    localparam logic [2:0] c_DONE  = 3'd7;

    logic [2:0]      r_state;
    logic            r_valid;
    logic [4:0]      r_len;
    logic [3:0]      r_step;
    logic [31:0]     r_timer;
    logic [15:0]     r_lfsr;
    logic [c_AW-1:0] r_gen_cnt;
    logic            r_draw_req;
    logic [1:0]      r_box_idx;
    logic            r_clear;
    logic            r_busy;
    logic            r_done;
    logic [1:0]      r_mem [0:c_DEPTH-1];

    logic            w_lfsr_fb;
    logic [4:0]      w_start_len;
    logic [3:0]      w_next_step;
    logic            w_more_steps;
    logic [1:0]      w_cur_box;
    logic [1:0]      w_next_box;

    // Taps 16,14,13,11 expressed on a right-shifting register.
    assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_next_step  = r_step + 4'd1;
    assign w_more_steps = ({1'b0, r_step} + 5'd1) < r_len;
    assign w_cur_box    = r_mem[r_step[c_AW-1:0]];
    assign w_next_box   = r_mem[w_next_step[c_AW-1:0]];

    always_comb begin
        w_start_len = {1'b0, iLevel};
        if (iLevel == 4'd0) begin
            w_start_len = 5'd1;
        end else if ({1'b0, iLevel} > c_MAX_LEN) begin
            w_start_len = c_MAX_LEN;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state    <= c_IDLE;
            r_valid    <= 1'b0;
            r_len      <= 5'd0;
            r_step     <= 4'd0;
            r_timer    <= 32'd0;
            r_lfsr     <= SEED;
            r_gen_cnt  <= '0;
            r_draw_req <= 1'b0;
            r_box_idx  <= 2'd0;
            r_clear    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (iStart) begin
                        r_len  <= w_start_len;
                        r_step <= 4'd0;
                        r_busy <= 1'b1;
                        if (iNewPattern || !r_valid) begin
                            r_state   <= c_GEN;
                            r_gen_cnt <= '0;
                        end else begin
                            r_state <= c_PRE;
                            r_timer <= c_OFF_LOAD;
                        end
                    end
                end
                c_GEN: begin
                    if (r_gen_cnt == c_GEN_LAST) begin
                        r_valid <= 1'b1;
                        r_state <= c_PRE;
                        r_timer <= c_OFF_LOAD;
                    end else begin
                        r_gen_cnt <= r_gen_cnt + 1'b1;
                    end
                end
                c_PRE: begin
                    if (r_timer == 32'd0) begin
                        r_state    <= c_DRAW;
                        r_draw_req <= 1'b1;
                        r_clear    <= 1'b0;
                        r_box_idx  <= w_cur_box;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_DRAW: begin
                    if (iDrawDone) begin
                        r_state    <= c_HOLD;
                        r_draw_req <= 1'b0;
                        r_timer    <= c_ON_LOAD;
                    end
                end
                c_HOLD: begin
                    if (r_timer == 32'd0) begin
                        r_state    <= c_ERASE;
                        r_draw_req <= 1'b1;
                        r_clear    <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_ERASE: begin
                    if (iDrawDone) begin
                        r_state    <= c_GAP;
                        r_draw_req <= 1'b0;
                        r_timer    <= c_OFF_LOAD;
                    end
                end
                c_GAP: begin
                    if (r_timer != 32'd0) begin
                        r_timer <= r_timer - 32'd1;
                    end else if (w_more_steps) begin
                        r_step     <= w_next_step;
                        r_state    <= c_DRAW;
                        r_draw_req <= 1'b1;
                        r_clear    <= 1'b0;
                        r_box_idx  <= w_next_box;
                    end else begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sequence storage is deliberately not reset; r_valid guards its use.
    always_ff @(posedge iClock) begin
        if (!iReset && r_state == c_GEN) begin
            r_mem[r_gen_cnt] <= r_lfsr[1:0];
        end
    end

    assign oRdData  = (32'(iRdAddr) < MAX_LEN) ? r_mem[iRdAddr[c_AW-1:0]] : 2'd0;
    assign oDrawReq = r_draw_req;
    assign oBoxIdx  = r_box_idx;
    assign oClear   = r_clear;
    assign oStep    = r_step;
    assign oBusy    = r_busy;
    assign oDone    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_sequencer
// Brief    : Self-checking bench; a segment-queue model predicts every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

    localparam int          MAX_LEN = 16;
    localparam int          ON      = 4;
    localparam int          OFF     = 2;
    localparam logic [15:0] SEED    = 16'hACE1;

    localparam int K_GEN   = 0;
    localparam int K_TIMED = 1;
    localparam int K_DRAW  = 2;
    localparam int K_ERASE = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int kind;
        int len;
        int step;
    } seg_t;

    logic       iClock;
    logic       iReset;
    logic       iStart;
    logic       iNewPattern;
    logic [3:0] iLevel;
    logic       iDrawDone;
    logic       oDrawReq;
    logic [1:0] oBoxIdx;
    logic       oClear;
    logic [3:0] oStep;
    logic       oBusy;
    logic       oDone;
    logic [3:0] iRdAddr;
    logic [1:0] oRdData;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;
    bit   dd_high = 1'b0;

    seg_t        q[$];
    int          seg_cnt;
    bit          m_valid;
    logic [15:0] m_lfsr;
    logic [1:0]  m_mem     [0:15];
    logic [1:0]  run_idx   [0:15];
    logic [1:0]  first_idx [0:15];

    pattern_sequencer #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .SEED       (SEED)
    ) u_dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iStart      (iStart),
        .iNewPattern (iNewPattern),
        .iLevel      (iLevel),
        .iDrawDone   (iDrawDone),
        .oDrawReq    (oDrawReq),
        .oBoxIdx     (oBoxIdx),
        .oClear      (oClear),
        .oStep       (oStep),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .iRdAddr     (iRdAddr),
        .oRdData     (oRdData)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] b;
        b = 16'(x[0] ^ x[2] ^ x[3] ^ x[5]);
        return (x >> 1) | (b << 15);
    endfunction

    // Model: playback is a queue of timed or handshake-terminated segments.
    always @(posedge iClock) begin
        if (iReset) begin
            q.delete();
            seg_cnt = 0;
            m_valid = 1'b0;
            m_lfsr  = SEED;
        end else begin
            if (q.size() == 0) begin
                if (iStart) begin
                    int len;
                    len = (iLevel == 4'd0) ? 1 : ((int'(iLevel) > MAX_LEN) ? MAX_LEN : int'(iLevel));
                    if (iNewPattern || !m_valid) q.push_back('{K_GEN, MAX_LEN, 0});
                    q.push_back('{K_TIMED, OFF, 0});
                    for (int s = 0; s < len; s++) begin
                        q.push_back('{K_DRAW, 0, s});
                        q.push_back('{K_TIMED, ON, s});
                        q.push_back('{K_ERASE, 0, s});
                        q.push_back('{K_TIMED, OFF, s});
                    end
                    q.push_back('{K_DONE, 1, 0});
                    seg_cnt = 0;
                end
            end else begin
                case (q[0].kind)
                    K_GEN: begin
                        m_mem[seg_cnt] = m_lfsr[1:0];
                        seg_cnt++;
                        if (seg_cnt == MAX_LEN) begin
                            m_valid = 1'b1;
                            void'(q.pop_front());
                            seg_cnt = 0;
                        end
                    end
                    K_TIMED: begin
                        seg_cnt++;
                        if (seg_cnt == q[0].len) begin
                            void'(q.pop_front());
                            seg_cnt = 0;
                        end
                    end
                    K_DRAW, K_ERASE: begin
                        if (iDrawDone) begin
                            void'(q.pop_front());
                            seg_cnt = 0;
                        end
                    end
                    default: begin
                        void'(q.pop_front());
                        seg_cnt = 0;
                    end
                endcase
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    bit e_busy, e_done, e_req, e_clear;
    int e_step;
    always @(negedge iClock) begin
        if (chk_en) begin
            e_busy  = (q.size() != 0);
            e_done  = e_busy && (q[0].kind == K_DONE);
            e_req   = e_busy && (q[0].kind == K_DRAW || q[0].kind == K_ERASE);
            e_clear = e_busy && (q[0].kind == K_ERASE);
            e_step  = e_busy ? q[0].step : 0;
            check("busy", oBusy, e_busy);
            check("done", oDone, e_done);
            check("draw_req", oDrawReq, e_req);
            if (e_req) begin
                check("clear", oClear, e_clear);
                check("step", oStep, e_step);
                check("box_idx", oBoxIdx, m_mem[e_step]);
            end
            if (m_valid) check("rd_data", oRdData, m_mem[iRdAddr]);
        end
    end

    // Datapath stand-in: done arrives on the third cycle of a request.
    initial begin
        int rc;
        rc = 0;
        iDrawDone = 1'b0;
        forever begin
            @(negedge iClock);
            if (dd_high) begin
                rc = 0;
                iDrawDone = 1'b1;
            end else if (oDrawReq) begin
                rc++;
                iDrawDone = (rc == 3);
            end else begin
                rc = 0;
                iDrawDone = 1'b0;
            end
        end
    end

    initial begin
        iRdAddr = 4'd0;
        forever begin
            @(posedge iClock);
            #2;
            iRdAddr = iRdAddr + 4'd1;
        end
    end

    task automatic play(input logic [3:0] lvl, input bit newp, input int exp_steps,
                        input int exp_lat, input int exp_hi, input bit poke);
        int t, draws, erases, dones, lat, hi, lo;
        bit prev_req, prev_done, finished;
        logic [1:0] box0;
        draws = 0; erases = 0; dones = 0; lat = -1; hi = 0; lo = 0;
        prev_req = 1'b0; prev_done = 1'b0; finished = 1'b0; box0 = 2'd0;
        @(negedge iClock);
        iStart = 1'b1; iNewPattern = newp; iLevel = lvl;
        @(negedge iClock);
        iStart = 1'b0; iNewPattern = 1'b0; iLevel = 4'd9;
        t = 1;
        while (t < 3000 && !finished) begin
            if (poke && t == 5) begin iStart = 1'b1; iNewPattern = 1'b1; iLevel = 4'd1; end
            if (poke && t == 6) begin iStart = 1'b0; iNewPattern = 1'b0; iLevel = 4'd9; end
            if (oDrawReq && !prev_req) begin
                if (oClear) begin
                    erases++;
                end else begin
                    draws++;
                    if (draws == 1) lat = t;
                    if (draws <= 16) run_idx[draws-1] = oBoxIdx;
                end
                if (draws + erases > 1) check(oClear ? "hold_cycles" : "gap_cycles", lo, oClear ? ON : OFF);
                hi = 0; lo = 0; box0 = oBoxIdx;
            end
            if (oDrawReq) begin
                hi++;
                check("box_stable", oBoxIdx, box0);
            end else begin
                if (prev_req) check("req_cycles", hi, exp_hi);
                lo++;
            end
            if (prev_done) begin
                check("busy_after_done", oBusy, 0);
                finished = 1'b1;
            end
            if (oDone) dones++;
            prev_req = oDrawReq; prev_done = oDone;
            if (!finished) begin
                @(negedge iClock);
                t++;
            end
        end
        check("play_finished", finished, 1);
        check("draw_count", draws, exp_steps);
        check("erase_count", erases, exp_steps);
        check("done_pulses", dones, 1);
        check("first_req_latency", lat, exp_lat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_req"}, oDrawReq, 0);
        check({tag, "_done"}, oDone, 0);
        check({tag, "_clear"}, oClear, 0);
        check({tag, "_box"}, oBoxIdx, 0);
        check({tag, "_step"}, oStep, 0);
    endtask

    task automatic abort_in_hold();
        int d;
        bit pr, found;
        d = 0; pr = 1'b0; found = 1'b0;
        @(negedge iClock);
        iStart = 1'b1; iNewPattern = 1'b0; iLevel = 4'd3;
        @(negedge iClock);
        iStart = 1'b0;
        for (int t = 0; t < 500 && !found; t++) begin
            if (oDrawReq && !pr && !oClear) d++;
            if (!oDrawReq && pr && d == 2) begin
                found = 1'b1;
            end else begin
                pr = oDrawReq;
                @(negedge iClock);
            end
        end
        check("abort_reached_hold", found, 1);
        check("abort_step_before", oStep, 1);
        iReset = 1'b1;
        @(negedge iClock);
        iReset = 1'b0;
        check_all_zero("abort");
    endtask

    initial begin
        logic [15:0] v;
        iReset = 1'b1; iStart = 1'b0; iNewPattern = 1'b0; iLevel = 4'd0;

        v = SEED;
        v = lfsr_step(v);
        check("lfsr_model_1", v, 16'h5670);
        v = lfsr_step(v);
        check("lfsr_model_2", v, 16'hAB38);

        repeat (3) @(negedge iClock);
        chk_en = 1'b1;
        check_all_zero("reset");
        iReset = 1'b0;
        repeat (5) @(negedge iClock);

        play(4'd3, 1'b0, 3, 1 + MAX_LEN + OFF, 3, 1'b0);
        for (int k = 0; k < 3; k++) first_idx[k] = run_idx[k];
        repeat (3) @(negedge iClock);

        play(4'd3, 1'b0, 3, 1 + OFF, 3, 1'b1);
        for (int k = 0; k < 3; k++) check("repeat_idx", run_idx[k], first_idx[k]);

        play(4'd0, 1'b0, 1, 1 + OFF, 3, 1'b0);
        play(4'd15, 1'b0, 15, 1 + OFF, 3, 1'b0);
        play(4'd2, 1'b1, 2, 1 + MAX_LEN + OFF, 3, 1'b0);

        abort_in_hold();
        play(4'd3, 1'b0, 3, 1 + MAX_LEN + OFF, 3, 1'b0);

        dd_high = 1'b1;
        @(negedge iClock);
        play(4'd4, 1'b0, 4, 1 + OFF, 1, 1'b0);
        dd_high = 1'b0;
        repeat (2) @(negedge iClock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pattern_sequencer.md
# pattern_sequencer

Sequencing controller for the memory game's pattern display. Generates a pseudo-random sequence of box indices and stores it. On start, it drives the box-drawing datapath through one draw/hold/erase/gap cycle per step, for `level` steps, using a request/done handshake. A read port exposes the stored sequence to the player-input checker.

## Interface
Parameters:
- `MAX_LEN`, 16 — sequence memory depth; the maximum level.
- `ON_CYCLES`, 50_000_000 — clock cycles a box stays lit (HOLD).
- `OFF_CYCLES`, 25_000_000 — blank cycles before the first box and between boxes (PRE/GAP).
- `SEED`, 16'hACE1 — LFSR reset value; must be nonzero.

Ports:
- `iClock` in 1 — single clock; all logic on its rising edge.
- `iReset` in 1 — synchronous, active-high reset.
- `iStart` in 1 — begin playback; sampled only in IDLE.
- `iNewPattern` in 1 — sampled with `iStart`; 1 = regenerate the sequence before playback.
- `iLevel` in 4 — number of steps to play; latched when the start is accepted.
- `iDrawDone` in 1 — datapath has finished the requested draw/erase.
- `oDrawReq` out 1 — draw request to the datapath.
- `oBoxIdx` out 2 — box index (0–3) for the current request.
- `oClear` out 1 — 0 = draw lit colour, 1 = erase to background.
- `oStep` out 4 — current step index, 0-based.
- `oBusy` out 1 — high in every state except IDLE.
- `oDone` out 1 — one-cycle pulse when playback completes.
- `iRdAddr` in 4 — read address into the sequence memory.
- `oRdData` out 2 — `mem[iRdAddr]`, combinational read.

## Operation
- States:
  - IDLE → GEN if `iStart` and (`iNewPattern` or !valid).
  - IDLE → PRE if `iStart` and valid and !`iNewPattern`.
  - GEN → PRE after MAX_LEN cycles.
  - PRE → DRAW when the timer expires.
  - DRAW → HOLD when `iDrawDone` is sampled.
  - HOLD → ERASE when the timer expires.
  - ERASE → GAP when `iDrawDone` is sampled.
  - GAP → DRAW with step+1 if step+1 < len; otherwise GAP → DONE.
  - DONE → IDLE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle in all states, so the pattern depends on when start is pressed.
  - Loaded with SEED on reset.
- GEN: writes `mem[k] <= lfsr[1:0]` for k = 0..MAX_LEN-1, one entry per cycle, then sets valid.
- Length latch: `len = (iLevel==0) ? 1 : min(iLevel, MAX_LEN)`.
- DRAW/ERASE outputs: `oDrawReq`=1, `oBoxIdx = mem[oStep]`, `oClear` = 0 in DRAW and 1 in ERASE.
- Handshake:
  - `oDrawReq`, `oBoxIdx` and `oClear` stay stable until the cycle in which `iDrawDone` is sampled high.
  - `oDrawReq` drops on the next cycle.
  - `iDrawDone` is ignored in all other states; a done that is already high on DRAW entry completes that request immediately.
- Timer:
  - Loads N-1 on entry to PRE, HOLD or GAP and decrements to 0.
  - The state exits on the cycle the count is 0, so the state occupies exactly N cycles.
- Ignored inputs: `iStart` outside IDLE; changes to `iLevel` after it is latched.
- Read port: `oRdData` is valid whenever valid=1. It returns the stale or reset contents otherwise (the checker must not read then).

## Timing
- Reset values:
  - State IDLE; valid=0; `oStep`=0; timer=0; LFSR=SEED.
  - `oDrawReq`, `oClear`, `oBoxIdx`, `oBusy`, `oDone` all 0.
  - Memory contents are not reset.
- Reset mid-operation: returns to IDLE on the next edge and drops `oDrawReq` the same edge. valid is cleared, so the next start regenerates.
- Start latency, with the start accepted at edge 0:
  - No regeneration: `oBusy`=1 from edge 1; `oDrawReq` first rises at edge 1+OFF_CYCLES.
  - With GEN: `oDrawReq` first rises at edge 1+MAX_LEN+OFF_CYCLES.
- Per-step period: OFF + ON + draw latency + erase latency, where each latency counts cycles from request to sampled done, inclusive (≥1).
- End of playback: `oDone` is high for exactly the one cycle after the final GAP ends; `oBusy` falls on the cycle after that.
- All outputs are registered except `oRdData`.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=16, and a datapath model that returns done 3 cycles after request.
- Reset, then start with `iNewPattern`=0 and `iLevel`=3 → GEN runs 16 cycles; `oRdData` over addresses 0–15 matches a software LFSR model from SEED; exactly 3 DRAW/ERASE pairs occur with `oBoxIdx` = mem[0..2]; one `oDone` pulse.
- Second start with `iNewPattern`=0 → no GEN; the first `oDrawReq` rises 3 cycles after the start (1+OFF); the indices equal the previous run.
- Timing per step → HOLD measures exactly 4 cycles and GAP exactly 2; `oClear`=0 on the draw request and 1 on the erase request; `oBoxIdx` stays stable while the request is high.
- `iLevel`=0 → one step; `iLevel`=15 → 15 steps; `iStart` pulsed while busy → no effect.
- `iReset` asserted during HOLD of step 1 → IDLE, all outputs 0 after one edge; the next start (with `iNewPattern`=0) still runs GEN.
- `iDrawDone` held constantly high → each DRAW and ERASE lasts exactly 1 cycle.
